// File: rtl/uart_wb_arbiter.sv
// rtl/uart_wb_arbiter.sv - round-robin arbiter sharing one UART register bus between two requesters
module uart_wb_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       r0_req,
    input  logic       r0_we,
    input  logic [1:0] r0_addr,
    input  logic [7:0] r0_wdata,
    output logic [7:0] r0_rdata,
    output logic       r0_done,
    output logic       r0_err,
    input  logic       r1_req,
    input  logic       r1_we,
    input  logic [1:0] r1_addr,
    input  logic [7:0] r1_wdata,
    output logic [7:0] r1_rdata,
    output logic       r1_done,
    output logic       r1_err,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_wdata,
    input  logic [7:0] wb_rdata,
    output logic       wb_we,
    output logic       wb_stb,
    output logic       wb_clk,
    input  logic       wb_ack,
    output logic [1:0] grant
);

    typedef enum logic [2:0] {IDLE, STROBE, RELEASE, DONE, HOLD} state_t;

    // Abort on the edge that would begin the (TIMEOUT+1)-th cycle in a phase.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic [7:0]  rd_hold_q, rd_hold_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  wb_addr_q, wb_addr_d;
    logic [7:0]  wb_wdata_q, wb_wdata_d;
    logic        wb_we_q, wb_we_d;
    logic        wb_stb_q, wb_stb_d;
    logic        wb_clk_q, wb_clk_d;
    logic [7:0]  r0_rdata_q, r0_rdata_d;
    logic        r0_done_q, r0_done_d;
    logic        r0_err_q, r0_err_d;
    logic [7:0]  r1_rdata_q, r1_rdata_d;
    logic        r1_done_q, r1_done_d;
    logic        r1_err_q, r1_err_d;

    logic pick;
    logic fin_ok;
    logic fin_to;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        rd_hold_d    = rd_hold_q;
        grant_d      = grant_q;
        wb_addr_d    = wb_addr_q;
        wb_wdata_d   = wb_wdata_q;
        wb_we_d      = wb_we_q;
        wb_stb_d     = wb_stb_q;
        wb_clk_d     = wb_clk_q;
        r0_rdata_d   = r0_rdata_q;
        r0_done_d    = r0_done_q;
        r0_err_d     = r0_err_q;
        r1_rdata_d   = r1_rdata_q;
        r1_done_d    = r1_done_q;
        r1_err_d     = r1_err_q;
        pick         = 1'b0;
        fin_ok       = 1'b0;
        fin_to       = 1'b0;

        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    pick       = (r0_req && r1_req) ? ~last_grant_q : r1_req;
                    owner_d    = pick;
                    wb_addr_d  = pick ? r1_addr  : r0_addr;
                    wb_wdata_d = pick ? r1_wdata : r0_wdata;
                    wb_we_d    = pick ? r1_we    : r0_we;
                    wb_stb_d   = 1'b1;
                    wb_clk_d   = 1'b1;
                    grant_d    = pick ? 2'b10 : 2'b01;
                    timer_d    = 16'd0;
                    state_d    = STROBE;
                end
            end
            STROBE: begin
                if (wb_ack) begin
                    // Read data is only guaranteed while ack is high, so keep a copy.
                    rd_hold_d = wb_rdata;
                    wb_clk_d  = 1'b0;
                    timer_d   = 16'd0;
                    state_d   = RELEASE;
                end else if (timer_q == TO_LAST) begin
                    fin_to = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            RELEASE: begin
                if (!wb_ack) begin
                    fin_ok = 1'b1;
                end else if (timer_q == TO_LAST) begin
                    fin_to = 1'b1;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            DONE: begin
                grant_d   = 2'b00;
                r0_done_d = 1'b0;
                r0_err_d  = 1'b0;
                r1_done_d = 1'b0;
                r1_err_d  = 1'b0;
                state_d   = HOLD;
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fin_ok || fin_to) begin
            wb_stb_d     = 1'b0;
            wb_clk_d     = 1'b0;
            last_grant_d = owner_q;
            state_d      = DONE;
            if (!owner_q) begin
                r0_done_d = fin_ok;
                r0_err_d  = fin_to;
                if (fin_to) begin
                    r0_rdata_d = 8'h00;
                end else if (wb_we_q) begin
                    r0_rdata_d = rd_hold_q;
                end
            end else begin
                r1_done_d = fin_ok;
                r1_err_d  = fin_to;
                if (fin_to) begin
                    r1_rdata_d = 8'h00;
                end else if (wb_we_q) begin
                    r1_rdata_d = rd_hold_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= 16'd0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            rd_hold_q    <= 8'h00;
            grant_q      <= 2'b00;
            wb_addr_q    <= 2'd0;
            wb_wdata_q   <= 8'h00;
            wb_we_q      <= 1'b0;
            wb_stb_q     <= 1'b0;
            wb_clk_q     <= 1'b0;
            r0_rdata_q   <= 8'h00;
            r0_done_q    <= 1'b0;
            r0_err_q     <= 1'b0;
            r1_rdata_q   <= 8'h00;
            r1_done_q    <= 1'b0;
            r1_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            rd_hold_q    <= rd_hold_d;
            grant_q      <= grant_d;
            wb_addr_q    <= wb_addr_d;
            wb_wdata_q   <= wb_wdata_d;
            wb_we_q      <= wb_we_d;
            wb_stb_q     <= wb_stb_d;
            wb_clk_q     <= wb_clk_d;
            r0_rdata_q   <= r0_rdata_d;
            r0_done_q    <= r0_done_d;
            r0_err_q     <= r0_err_d;
            r1_rdata_q   <= r1_rdata_d;
            r1_done_q    <= r1_done_d;
            r1_err_q     <= r1_err_d;
        end
    end

    assign r0_rdata = r0_rdata_q;
    assign r0_done  = r0_done_q;
    assign r0_err   = r0_err_q;
    assign r1_rdata = r1_rdata_q;
    assign r1_done  = r1_done_q;
    assign r1_err   = r1_err_q;
    assign wb_addr  = wb_addr_q;
    assign wb_wdata = wb_wdata_q;
    assign wb_we    = wb_we_q;
    assign wb_stb   = wb_stb_q;
    assign wb_clk   = wb_clk_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// tb/tb_uart_wb_arbiter.sv - directed vector bench for uart_wb_arbiter
module tb_uart_wb_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       r0_req, r0_we, r1_req, r1_we;
    logic [1:0] r0_addr, r1_addr;
    logic [7:0] r0_wdata, r1_wdata;
    logic [7:0] r0_rdata, r1_rdata;
    logic       r0_done, r0_err, r1_done, r1_err;
    logic [1:0] wb_addr;
    logic [7:0] wb_wdata, wb_rdata;
    logic       wb_we, wb_stb, wb_clk;
    logic       wb_ack;
    logic [1:0] grant;

    always #5 clk = ~clk;

    uart_wb_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rdata(r0_rdata), .r0_done(r0_done), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rdata(r1_rdata), .r1_done(r1_done), .r1_err(r1_err),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
        .wb_we(wb_we), .wb_stb(wb_stb), .wb_clk(wb_clk), .wb_ack(wb_ack),
        .grant(grant)
    );

    // UART model: ack two cycles after wb_clk rises, drop it one cycle after wb_clk falls.
    logic       model_noack = 1'b0;
    logic [7:0] model_data  = 8'h00;
    logic [1:0] mcnt;

    always @(posedge clk) begin
        if (reset) begin
            wb_ack <= 1'b0;
            mcnt   <= 2'd0;
        end else if (wb_clk && !wb_ack && !model_noack) begin
            if (mcnt == 2'd1) wb_ack <= 1'b1;
            mcnt <= mcnt + 2'd1;
        end else if (!wb_clk) begin
            mcnt <= 2'd0;
            if (wb_ack) wb_ack <= 1'b0;
        end
    end

    assign wb_rdata = wb_ack ? model_data : 8'h00;

    int checks = 0;
    int failures = 0;
    int hold_bad = 0;
    int pulse_bad = 0;

    logic        prev_stb = 1'b0;
    logic [12:0] prev_fields = 13'd0;

    always @(negedge clk) begin
        if (wb_stb && prev_stb && ({wb_addr, wb_we, wb_wdata, grant} != prev_fields)) hold_bad++;
        if ((r0_done && r0_err) || (r1_done && r1_err) ||
            ((r0_done || r0_err) && (r1_done || r1_err)) || (grant == 2'b11)) pulse_bad++;
        prev_stb    = wb_stb;
        prev_fields = {wb_addr, wb_we, wb_wdata, grant};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic txn(input logic who, input logic we, input logic [1:0] addr,
                       input logic [7:0] wdata, input logic [7:0] mdata,
                       output int lat, output logic got_done, output logic got_err,
                       output logic [1:0] first_grant, output logic [10:0] fields);
        model_data = mdata;
        if (!who) begin
            r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_req = 1'b1;
        end else begin
            r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_req = 1'b1;
        end
        lat = 0; got_done = 1'b0; got_err = 1'b0; first_grant = 2'b00; fields = 11'd0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (first_grant == 2'b00 && grant != 2'b00) begin
                first_grant = grant;
                fields = {wb_addr, wb_we, wb_wdata};
            end
            if (who ? r1_done : r0_done) begin got_done = 1'b1; lat = i; break; end
            if (who ? r1_err : r0_err) begin got_err = 1'b1; lat = i; break; end
        end
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    typedef struct {
        logic       who;
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] mdata;
        logic [7:0] exp_r0;
        logic [7:0] exp_r1;
    } vec_t;

    vec_t vecs[6];

    int          lat;
    logic        gd, ge;
    logic [1:0]  fg;
    logic [10:0] fl;
    int          cnt0, cnt1, ndone, nbad;
    logic [1:0]  prevg;
    logic [1:0]  order[$];
    logic        found;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 2'd0, 8'h55, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b1, 2'd1, 8'h00, 8'hA5, 8'h00, 8'hA5};
        vecs[2] = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h3C, 8'h3C, 8'hA5};
        vecs[3] = '{1'b1, 1'b0, 2'd2, 8'h12, 8'h77, 8'h3C, 8'hA5};
        vecs[4] = '{1'b0, 1'b1, 2'd1, 8'h00, 8'hFF, 8'hFF, 8'hA5};
        vecs[5] = '{1'b1, 1'b1, 2'd0, 8'h00, 8'hC3, 8'hFF, 8'hC3};

        reset = 1'b1;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = 2'd0; r0_wdata = 8'h00;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = 2'd0; r1_wdata = 8'h00;
        idle(3);
        chk("reset_bus", {wb_stb, wb_clk, wb_we, wb_addr, wb_wdata}, 32'd0);
        chk("reset_grant", {30'd0, grant}, 32'd0);
        chk("reset_r0", {r0_rdata, r0_done, r0_err}, 32'd0);
        chk("reset_r1", {r1_rdata, r1_done, r1_err}, 32'd0);
        reset = 1'b0;

        // Both requesters, three writes each, asserted together straight out of reset.
        r0_we = 1'b0; r0_addr = 2'd0; r0_wdata = 8'h11;
        r1_we = 1'b0; r1_addr = 2'd2; r1_wdata = 8'h22;
        cnt0 = 3; cnt1 = 3; ndone = 0; prevg = 2'b00;
        r0_req = 1'b1; r1_req = 1'b1;
        for (int i = 0; i < 200 && (cnt0 > 0 || cnt1 > 0); i++) begin
            @(negedge clk);
            if (grant != 2'b00 && prevg == 2'b00) order.push_back(grant);
            prevg = grant;
            if (r0_done) begin ndone++; cnt0--; if (cnt0 == 0) r0_req = 1'b0; end
            if (r1_done) begin ndone++; cnt1--; if (cnt1 == 0) r1_req = 1'b0; end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        chk("rr_done_count", ndone, 6);
        chk("rr_grant_count", order.size(), 6);
        for (int k = 0; k < 6; k++) begin
            logic [1:0] g;
            g = (k < order.size()) ? order[k] : 2'b00;
            chk($sformatf("rr_order_%0d", k), {30'd0, g}, (k % 2 == 1) ? 32'd2 : 32'd1);
        end
        idle(3);

        for (int v = 0; v < 6; v++) begin
            txn(vecs[v].who, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].mdata, lat, gd, ge, fg, fl);
            chk($sformatf("v%0d_grant", v), {30'd0, fg}, vecs[v].who ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_fields", v), {21'd0, fl}, {21'd0, vecs[v].addr, vecs[v].we, vecs[v].wdata});
            chk($sformatf("v%0d_done", v), {31'd0, gd}, 32'd1);
            chk($sformatf("v%0d_latency", v), lat, 6);
            chk($sformatf("v%0d_r0_rdata", v), {24'd0, r0_rdata}, {24'd0, vecs[v].exp_r0});
            chk($sformatf("v%0d_r1_rdata", v), {24'd0, r1_rdata}, {24'd0, vecs[v].exp_r1});
            @(negedge clk);
            chk($sformatf("v%0d_pulse_clear", v), {r0_done, r1_done, wb_stb}, 32'd0);
            idle(3);
        end

        // Silent UART: abort after 8 cycles in STROBE, then a normal read by r1.
        model_noack = 1'b1;
        txn(1'b0, 1'b1, 2'd1, 8'h00, 8'h99, lat, gd, ge, fg, fl);
        chk("to_err", {30'd0, gd, ge}, 32'd1);
        chk("to_latency", lat, 9);
        chk("to_bus_low", {wb_stb, wb_clk}, 32'd0);
        chk("to_r0_rdata", {24'd0, r0_rdata}, 32'd0);
        @(negedge clk);
        chk("to_err_clear", {31'd0, r0_err}, 32'd0);
        model_noack = 1'b0;
        idle(3);
        txn(1'b1, 1'b1, 2'd1, 8'h00, 8'h5A, lat, gd, ge, fg, fl);
        chk("after_to_r1_done", {30'd0, gd, ge}, 32'd2);
        chk("after_to_r1_rdata", {24'd0, r1_rdata}, 32'h5A);
        idle(3);

        // Reset landing in RELEASE drops the transaction without a pulse.
        model_data = 8'h66;
        r0_we = 1'b1; r0_addr = 2'd1; r0_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_stb && !wb_clk) begin found = 1'b1; break; end
        end
        chk("rst_reached_release", {31'd0, found}, 32'd1);
        reset = 1'b1; r0_req = 1'b0;
        @(negedge clk);
        chk("rst_bus", {wb_stb, wb_clk, wb_we, wb_addr, wb_wdata}, 32'd0);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_outs", {r0_rdata, r1_rdata, r0_done, r0_err, r1_done, r1_err}, 32'd0);
        reset = 1'b0;
        nbad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (r0_done || r0_err || r1_done || r1_err || grant != 2'b00) nbad++;
        end
        chk("rst_quiet", nbad, 0);
        r0_we = 1'b0; r1_we = 1'b0;
        r0_req = 1'b1; r1_req = 1'b1;
        fg = 2'b00; gd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fg == 2'b00 && grant != 2'b00) fg = grant;
            if (r0_done) begin gd = 1'b1; break; end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        chk("rst_first_grant", {30'd0, fg}, 32'd1);
        chk("rst_r0_done", {31'd0, gd}, 32'd1);
        idle(4);

        // r0 keeps req up one cycle past done; HOLD must absorb it.
        r0_we = 1'b0; r0_addr = 2'd2; r0_wdata = 8'h0F; r0_req = 1'b1;
        gd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r0_done) begin gd = 1'b1; break; end
        end
        chk("hold_first_done", {31'd0, gd}, 32'd1);
        idle(2);
        r0_req = 1'b0;
        nbad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (grant != 2'b00 || wb_stb) nbad++;
        end
        chk("hold_no_second", nbad, 0);
        txn(1'b0, 1'b0, 2'd0, 8'hE1, 8'h00, lat, gd, ge, fg, fl);
        chk("hold_fresh_grant", {30'd0, fg}, 32'd1);
        chk("hold_fresh_done", {30'd0, gd, ge}, 32'd2);
        idle(3);

        chk("addr_data_held", hold_bad, 0);
        chk("pulse_exclusive", pulse_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
